// File: rtl/tlb_entry_writer_if.sv
// Command, RAM-access and response signals of the L2 TLB entry writer.
// The slave modport is the writer's view; the master modport is the environment's view.
interface tlb_entry_writer_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int SET_WIDTH    = 5,
  parameter int OFFSET_WIDTH = 4
);
  localparam int IDX_W = SET_WIDTH + OFFSET_WIDTH + 1;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_inval_i;
  logic [ADDR_WIDTH-1:0] req_va_i;
  logic                  req_rd_i;
  logic                  req_wr_i;
  logic                  req_master_i;
  logic                  ram_req_o;
  logic                  ram_gnt_i;
  logic                  ram_we_o;
  logic [IDX_W-1:0]      ram_addr_o;
  logic [31:0]           ram_wdata_o;
  logic [31:0]           ram_rdata_i;
  logic                  resp_valid_o;
  logic                  resp_ready_i;
  logic [1:0]            resp_status_o;
  logic [IDX_W-1:0]      resp_idx_o;

  modport slave (
    input  req_valid_i, req_inval_i, req_va_i, req_rd_i, req_wr_i, req_master_i,
    input  ram_gnt_i, ram_rdata_i, resp_ready_i,
    output req_ready_o, ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o,
    output resp_valid_o, resp_status_o, resp_idx_o
  );

  modport master (
    output req_valid_i, req_inval_i, req_va_i, req_rd_i, req_wr_i, req_master_i,
    output ram_gnt_i, ram_rdata_i, resp_ready_i,
    input  req_ready_o, ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o,
    input  resp_valid_o, resp_status_o, resp_idx_o
  );
endinterface

// File: rtl/tlb_entry_writer.sv
// L2 TLB entry writer: scans a set for the VPN, then inserts, updates in place or
// invalidates, so a VPN never occupies two ways of one set.
module tlb_entry_writer #(
  parameter int ADDR_WIDTH   = 32,
  parameter int PAGE_SIZE    = 4096,
  parameter int SET_WIDTH    = 5,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  tlb_entry_writer_if.slave  bus
);
  localparam int IGNORE_LSB = $clog2(PAGE_SIZE);
  localparam int VPN_W      = ADDR_WIDTH - IGNORE_LSB;
  localparam int SIDX_W     = SET_WIDTH + 1;
  localparam int IDX_W      = SET_WIDTH + OFFSET_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, RESP} state_t;

  state_t                  state;
  logic                    inval_q;
  logic [VPN_W-1:0]        vpn_q;
  logic [2:0]              flags_q;
  logic [SIDX_W-1:0]       set_q;
  logic [OFFSET_WIDTH-1:0] scan_idx;
  logic                    issue_done;
  logic                    rd_vld_p1;
  logic [OFFSET_WIDTH-1:0] rd_idx_p1;
  logic                    free_found;
  logic [OFFSET_WIDTH-1:0] free_idx;
  logic [OFFSET_WIDTH-1:0] tgt_idx;
  logic                    tgt_hit;
  logic [1:0]              status_q;
  logic [IDX_W-1:0]        resp_idx_q;

  logic                    rd_entry_vld;
  logic                    rd_hit;
  logic                    rd_last;

  // Entry word: {0.., VPN, master, write, read, valid}
  function automatic logic [31:0] make_entry(input logic [VPN_W-1:0] vpn,
                                             input logic [2:0] flags);
    logic [31:0] w;
    w              = '0;
    w[4 +: VPN_W]  = vpn;
    w[3:0]         = {flags, 1'b1};
    return w;
  endfunction

  assign rd_entry_vld = bus.ram_rdata_i[0];
  assign rd_hit       = rd_vld_p1 && rd_entry_vld && (bus.ram_rdata_i[4 +: VPN_W] == vpn_q);
  assign rd_last      = (rd_idx_p1 == {OFFSET_WIDTH{1'b1}});

  assign bus.req_ready_o   = (state == IDLE);
  assign bus.resp_valid_o  = (state == RESP);
  assign bus.ram_req_o     = ((state == SCAN) && !issue_done) || (state == WRITE);
  assign bus.ram_we_o      = (state == WRITE) && bus.ram_gnt_i;
  assign bus.ram_addr_o    = (state == SCAN)  ? {set_q, scan_idx} :
                             (state == WRITE) ? {set_q, tgt_idx}  : '0;
  assign bus.ram_wdata_o   = ((state == WRITE) && !inval_q) ? make_entry(vpn_q, flags_q) : '0;
  assign bus.resp_status_o = status_q;
  assign bus.resp_idx_o    = resp_idx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      inval_q    <= 1'b0;
      vpn_q      <= '0;
      flags_q    <= '0;
      set_q      <= '0;
      scan_idx   <= '0;
      issue_done <= 1'b0;
      rd_vld_p1  <= 1'b0;
      rd_idx_p1  <= '0;
      free_found <= 1'b0;
      free_idx   <= '0;
      tgt_idx    <= '0;
      tgt_hit    <= 1'b0;
      status_q   <= '0;
      resp_idx_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            inval_q    <= bus.req_inval_i;
            vpn_q      <= bus.req_va_i[ADDR_WIDTH-1:IGNORE_LSB];
            flags_q    <= {bus.req_master_i, bus.req_wr_i, bus.req_rd_i};
            set_q      <= bus.req_va_i[IGNORE_LSB +: SIDX_W];
            scan_idx   <= '0;
            issue_done <= 1'b0;
            rd_vld_p1  <= 1'b0;
            free_found <= 1'b0;
            state      <= SCAN;
          end
        end

        SCAN: begin
          // issue stage: one read per granted cycle
          rd_vld_p1 <= 1'b0;
          if (!issue_done && bus.ram_gnt_i) begin
            rd_vld_p1 <= 1'b1;
            rd_idx_p1 <= scan_idx;
            scan_idx  <= scan_idx + 1'b1;
            if (scan_idx == {OFFSET_WIDTH{1'b1}}) issue_done <= 1'b1;
          end
          // compare stage: data of the read issued last cycle
          if (rd_hit) begin
            tgt_idx   <= rd_idx_p1;
            tgt_hit   <= 1'b1;
            rd_vld_p1 <= 1'b0;
            state     <= WRITE;
          end else if (rd_vld_p1) begin
            if (!rd_entry_vld && !free_found) begin
              free_found <= 1'b1;
              free_idx   <= rd_idx_p1;
            end
            if (rd_last) begin
              if (inval_q) begin
                status_q   <= 2'b11;
                resp_idx_q <= '0;
                state      <= RESP;
              end else if (free_found || !rd_entry_vld) begin
                tgt_idx <= free_found ? free_idx : rd_idx_p1;
                tgt_hit <= 1'b0;
                state   <= WRITE;
              end else begin
                status_q   <= 2'b10;
                resp_idx_q <= '0;
                state      <= RESP;
              end
            end
          end
        end

        WRITE: begin
          if (bus.ram_gnt_i) begin
            status_q   <= tgt_hit ? 2'b01 : 2'b00;
            resp_idx_q <= {set_q, tgt_idx};
            state      <= RESP;
          end
        end

        RESP: begin
          if (bus.resp_ready_i) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tlb_entry_writer.sv
// Directed bench for tlb_entry_writer with a behavioural RAM and an expectation queue.
module tb_tlb_entry_writer;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  tlb_entry_writer_if bus ();

  tlb_entry_writer dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // RAM model: one-cycle read latency, garbage when the read was not granted
  logic [31:0] ram [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk_i) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (bus.ram_we_o) ram[bus.ram_addr_o] <= bus.ram_wdata_o;
    if (bus.ram_req_o && bus.ram_gnt_i && !bus.ram_we_o) bus.ram_rdata_i <= ram[bus.ram_addr_o];
    else bus.ram_rdata_i <= $urandom;
  end

  typedef struct {
    bit          we;
    int          we_cyc;
    logic [9:0]  addr;
    logic [31:0] data;
    int          resp_cyc;
    logic [1:0]  st;
    logic [9:0]  idx;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clk_i);
    pl_en   = 1'b0;
  endtask

  task automatic run_cmd(input bit inval, input logic [31:0] va, input bit rd, input bit wr,
                         input bit m, input exp_t e, input int goff_lo, input int goff_hi,
                         input int rdy_from, input int rst_at);
    bit seen_we;
    bit seen_resp;
    bit done;
    seen_we   = 0;
    seen_resp = 0;
    done      = 0;
    sb.push_back(e);
    chk("ready_idle", bus.req_ready_o, 1);
    bus.req_inval_i  = inval;
    bus.req_va_i     = va;
    bus.req_rd_i     = rd;
    bus.req_wr_i     = wr;
    bus.req_master_i = m;
    bus.ram_gnt_i    = 1'b1;
    bus.resp_ready_i = (rdy_from <= 0);
    bus.req_valid_i  = 1'b1;
    @(negedge clk_i);
    bus.req_valid_i  = 1'b0;
    for (int c = 1; c <= 80 && !done; c++) begin
      bus.ram_gnt_i    = !(c >= goff_lo && c <= goff_hi);
      bus.resp_ready_i = (c >= rdy_from);
      #1;
      if (c == 1) chk("ready_busy", bus.req_ready_o, 0);
      if (c == rst_at) begin
        chk("scan_req", bus.ram_req_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("rst_req", bus.ram_req_o, 0);
        chk("rst_we", bus.ram_we_o, 0);
        chk("rst_addr", bus.ram_addr_o, 0);
        chk("rst_vld", bus.resp_valid_o, 0);
        chk("rst_no_we_seen", seen_we, 0);
        void'(sb.pop_front());
        done = 1;
      end else begin
        if (bus.ram_we_o) begin
          seen_we = 1;
          chk("we_expected", 1, sb[0].we);
          chk("we_cyc", c, sb[0].we_cyc);
          chk("we_gnt", bus.ram_gnt_i, 1);
          chk("we_addr", bus.ram_addr_o, sb[0].addr);
          chk("we_data", bus.ram_wdata_o, sb[0].data);
        end
        if (bus.resp_valid_o) begin
          if (!seen_resp) begin
            seen_resp = 1;
            chk("resp_cyc", c, sb[0].resp_cyc);
            chk("we_seen", seen_we, sb[0].we);
          end
          chk("resp_st", bus.resp_status_o, sb[0].st);
          chk("resp_idx", bus.resp_idx_o, sb[0].idx);
          if (bus.resp_ready_i) begin
            void'(sb.pop_front());
            done = 1;
          end
        end
      end
      @(negedge clk_i);
    end
    if (rst_at > 0) rst_ni = 1'b1;
    chk("done", done, 1);
    if (!done) sb.delete();
  endtask

  function automatic exp_t mk(bit we, int we_cyc, logic [9:0] addr, logic [31:0] data,
                              int resp_cyc, logic [1:0] st, logic [9:0] idx);
    exp_t e;
    e.we = we; e.we_cyc = we_cyc; e.addr = addr; e.data = data;
    e.resp_cyc = resp_cyc; e.st = st; e.idx = idx;
    return e;
  endfunction

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.req_inval_i  = 1'b0;
    bus.req_va_i     = '0;
    bus.req_rd_i     = 1'b0;
    bus.req_wr_i     = 1'b0;
    bus.req_master_i = 1'b0;
    bus.ram_gnt_i    = 1'b1;
    bus.resp_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("r_ready", bus.req_ready_o, 1);
    chk("r_vld", bus.resp_valid_o, 0);
    chk("r_req", bus.ram_req_o, 0);
    chk("r_we", bus.ram_we_o, 0);
    chk("r_addr", bus.ram_addr_o, 0);
    chk("r_wdata", bus.ram_wdata_o, 0);
    chk("r_st", bus.resp_status_o, 0);
    chk("r_idx", bus.resp_idx_o, 0);
    @(negedge clk_i);
    for (int a = 'h50; a < 'h80; a++) poke(10'(a), 32'h0);

    // empty set: insert at way 0
    run_cmd(0, 32'h0004_5000, 1, 0, 1, mk(1, 18, 10'h050, 32'h0000_045B, 19, 2'b00, 10'h050), 0, -1, 0, 0);

    // ways 0-2 hold other VPNs, way 3 free
    poke(10'h050, 32'h0000_0851);
    poke(10'h051, 32'h0000_0C51);
    poke(10'h052, 32'h0000_1051);
    poke(10'h053, 32'h0000_0000);
    run_cmd(0, 32'h0004_5000, 1, 0, 1, mk(1, 18, 10'h053, 32'h0000_045B, 19, 2'b00, 10'h053), 0, -1, 0, 0);

    // same VPN again: in-place update at way 3
    run_cmd(0, 32'h0004_5000, 1, 1, 1, mk(1, 6, 10'h053, 32'h0000_045F, 7, 2'b01, 10'h053), 0, -1, 0, 0);

    // fill the rest of set 5 with distinct VPNs
    for (int k = 4; k < 16; k++) poke(10'('h50 + k), ((32'h205 + 32'h40 * (k - 4)) << 4) | 32'h1);
    run_cmd(0, 32'h0014_5000, 1, 0, 0, mk(0, 0, 10'h0, 32'h0, 18, 2'b10, 10'h000), 0, -1, 0, 0);
    run_cmd(1, 32'h001C_5000, 0, 0, 0, mk(0, 0, 10'h0, 32'h0, 18, 2'b11, 10'h000), 0, -1, 0, 0);
    run_cmd(1, 32'h0004_5000, 0, 0, 0, mk(1, 6, 10'h053, 32'h0000_0000, 7, 2'b01, 10'h053), 0, -1, 0, 0);

    // grant gap during scan and delayed response consumption
    run_cmd(0, 32'h0004_6000, 1, 1, 0, mk(1, 21, 10'h060, 32'h0000_0467, 22, 2'b00, 10'h060), 4, 6, 24, 0);

    // reset in the middle of a scan, then a clean retry
    run_cmd(0, 32'h0004_7000, 0, 1, 0, mk(1, 18, 10'h070, 32'h0000_0475, 19, 2'b00, 10'h070), 0, -1, 0, 8);
    @(negedge clk_i);
    chk("rst_ram_untouched", ram[10'h070], 32'h0);
    run_cmd(0, 32'h0004_7000, 0, 1, 0, mk(1, 18, 10'h070, 32'h0000_0475, 19, 2'b00, 10'h070), 0, -1, 0, 0);
    chk("ram_written", ram[10'h070], 32'h0000_0475);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tlb_entry_writer.md
Name: tlb_entry_writer

Overview:
- Programming side of the L2 TLB set-associative RAM: inserts, updates and invalidates translation entries in the same RAM the lookup logic searches.
- Scans the target set before writing, so one VPN never occupies two entries of a set. This prevents multi-hits at lookup.
- Sits between the configuration port and the RAM's shared write/port0 access. The lookup side arbitrates RAM access via ram_req/ram_gnt.

Parameters:
ADDR_WIDTH, 32, virtual address width
PAGE_SIZE, 4096, page size in bytes; IGNORE_LSB = log2(PAGE_SIZE)
SET_WIDTH, 5, set index is SET_WIDTH+1 bits
OFFSET_WIDTH, 4, 2^OFFSET_WIDTH entries per set

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
req_valid_i  in  1  command valid
req_ready_o  out  1  command accepted when valid&ready
req_inval_i  in  1  1 = invalidate, 0 = insert/update
req_va_i  in  ADDR_WIDTH  virtual address; bits below IGNORE_LSB ignored
req_rd_i  in  1  read permission
req_wr_i  in  1  write permission
req_master_i  in  1  master flag
ram_req_o  out  1  request RAM access this cycle
ram_gnt_i  in  1  access granted this cycle (lookup has priority)
ram_we_o  out  1  RAM write enable
ram_addr_o  out  SET_WIDTH+OFFSET_WIDTH+1  {set, entry index}
ram_wdata_o  out  32  RAM write data
ram_rdata_i  in  32  RAM read data, one cycle after a granted read address
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response consumed
resp_status_o  out  2  00 inserted new, 01 updated existing, 10 set full, 11 invalidate miss
resp_idx_o  out  SET_WIDTH+OFFSET_WIDTH+1  RAM address written; 0 for status 10/11

Behaviour:
- Entry word layout:
  - bit0 valid; bit1 read; bit2 write; bit3 master.
  - [4+VPN_W-1:4] VPN, where VPN_W = ADDR_WIDTH-IGNORE_LSB.
  - Upper bits written 0.
- Set index = req_va_i[IGNORE_LSB+SET_WIDTH:IGNORE_LSB], captured at accept.
- Async reset:
  - State returns to IDLE.
  - ram_we_o, ram_req_o, resp_valid_o are 0.
  - ram_addr_o, ram_wdata_o, resp_status_o, resp_idx_o are 0.
  - An in-flight operation is abandoned; no partial write occurs.
- IDLE:
  - req_ready_o = 1.
  - On accept, capture command, VPN, flags and set; go to SCAN. Clear scan index, free_found, match_found.
- SCAN:
  - Drive ram_req_o = 1 and ram_addr_o = {set, scan_idx}.
  - If ram_gnt_i, mark read pending with its index and increment scan_idx. Issuing stops after the last index.
  - If no grant, the index holds and no read is pending. Data returned in the following cycle is ignored.
  - Compare a pending read's data one cycle later:
    - valid and VPN equal → match: record index; next state WRITE (insert) or WRITE with zero data (invalidate). Outstanding reads are discarded.
    - invalid and no free index yet → record as first free.
  - After compare of the last index without a match:
    - insert with free → WRITE at the free index;
    - insert without free → RESP, status 10;
    - invalidate → RESP, status 11.
  - Match has priority over free, so update is always in place.
- WRITE:
  - ram_req_o = 1 and ram_addr_o = target.
  - ram_wdata_o = entry word, or 0 for invalidate.
  - ram_we_o = ram_gnt_i. Stay until granted, then go to RESP.
  - Status: 00 if free slot, 01 if match; invalidate hit reports 01.
- RESP:
  - resp_valid_o = 1; status and idx held stable until resp_ready_i. Then go to IDLE.
  - req_ready_o = 0 in every state except IDLE; no request overlap.
- Latency, continuous grant, no match, 16 entries:
  - accept cycle 0; reads issued cycles 1-16; compares cycles 2-17;
  - ram_we_o cycle 18; resp_valid_o cycle 19.
  - A match at index k writes in cycle k+3.
- ram_we_o is never asserted outside WRITE and never without ram_gnt_i.

Test Plan:
- Empty RAM, insert va=0x0004_5000, rd=1 wr=0 master=1 → ram_we_o at cycle 18, addr 0x050, wdata 0x0000_045B; resp 00, idx 0x050 at cycle 19.
- Set 5 idx0-2 valid (VPN 0x85, 0xC5, 0x105), idx3 invalid; insert va 0x0004_5000 → write addr 0x053, status 00.
- Repeat insert of va 0x0004_5000 with wr=1, entry at idx3 → write addr 0x053, wdata 0x0000_045F, status 01, ram_we_o at cycle 6.
- All 16 entries of set 5 valid, distinct VPNs, insert new VPN 0x145 → no ram_we_o, status 10 at cycle 18. Invalidate VPN 0x1C5 absent → status 11. Invalidate VPN at idx3 → wdata 0, addr 0x053, status 01.
- ram_gnt_i low for cycles 4-6 during SCAN, plus resp_ready_i low 2 cycles → same result, latency +3, response held stable.
- rst_ni low during SCAN cycle 8 → outputs 0 asynchronously, no write occurs; next request completes normally.
